// File: rtl/speed_pkg.sv
// rtl/speed_pkg.sv - shared speed/status encoding for speed_ctrl and the display stage
package speed_pkg;

  localparam logic [1:0] ST_LOW   = 2'd0;
  localparam logic [1:0] ST_MID   = 2'd1;
  localparam logic [1:0] ST_HIGH  = 2'd2;
  localparam logic [1:0] ST_PAUSE = 2'd3;

  typedef enum logic [1:0] {
    S_LOW   = ST_LOW,
    S_MID   = ST_MID,
    S_HIGH  = ST_HIGH,
    S_PAUSE = ST_PAUSE
  } speed_state_t;

endpackage

// File: rtl/button_debounce.sv
// rtl/button_debounce.sv - two-flop synchroniser, stability counter and press pulse for one button
module button_debounce #(
  parameter int DEBOUNCE_CYCLES = 1_000_000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn,
  output logic stable,
  output logic press
);

  localparam int             CW      = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0]  CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

  logic          meta;
  logic          sync;
  logic          stable_q;
  logic [CW-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta     <= 1'b0;
      sync     <= 1'b0;
      stable   <= 1'b0;
      stable_q <= 1'b0;
      press    <= 1'b0;
      cnt      <= '0;
    end else begin
      meta <= btn;
      sync <= meta;
      // Any sample that agrees with the accepted level restarts the count.
      if (sync == stable) begin
        cnt <= '0;
      end else if (cnt == CNT_MAX) begin
        stable <= sync;
        cnt    <= '0;
      end else begin
        cnt <= cnt + CW'(1);
      end
      stable_q <= stable;
      press    <= stable & ~stable_q;
    end
  end

endmodule

// File: rtl/speed_ctrl.sv
// rtl/speed_ctrl.sv - debounced front-panel buttons driving the four-state speed FSM
module speed_ctrl #(
  parameter int DEBOUNCE_CYCLES = 1_000_000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       btn_up,
  input  logic       btn_down,
  input  logic       btn_pause,
  output logic [1:0] status,
  output logic       paused
);
  import speed_pkg::*;

  logic         press_up;
  logic         press_down;
  logic         press_pause;
  logic [2:0]   unused_stable;

  speed_state_t state;
  speed_state_t state_next;
  logic [1:0]   saved_speed;
  logic [1:0]   saved_next;

  button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_up (
    .clk(clk), .rst_n(rst_n), .btn(btn_up), .stable(unused_stable[0]), .press(press_up)
  );
  button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_down (
    .clk(clk), .rst_n(rst_n), .btn(btn_down), .stable(unused_stable[1]), .press(press_down)
  );
  button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_pause (
    .clk(clk), .rst_n(rst_n), .btn(btn_pause), .stable(unused_stable[2]), .press(press_pause)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_LOW;
      saved_speed <= ST_LOW;
      paused      <= 1'b0;
    end else begin
      state       <= state_next;
      saved_speed <= saved_next;
      paused      <= (state_next == S_PAUSE);
    end
  end

  // Pause wins over up/down; up and down together cancel.
  always_comb begin
    state_next = state;
    saved_next = saved_speed;
    if (state == S_PAUSE) begin
      if (press_pause) state_next = speed_state_t'(saved_speed);
    end else if (press_pause) begin
      saved_next = state;
      state_next = S_PAUSE;
    end else if (press_up && !press_down) begin
      case (state)
        S_LOW:   state_next = S_MID;
        default: state_next = S_HIGH;
      endcase
    end else if (press_down && !press_up) begin
      case (state)
        S_HIGH:  state_next = S_MID;
        default: state_next = S_LOW;
      endcase
    end
  end

  assign status = state;

endmodule

// File: tb/tb_speed_ctrl.sv
// tb/tb_speed_ctrl.sv - scoreboard bench for speed_ctrl with a behavioural button/speed model
module tb_speed_ctrl;

  localparam int DB = 4;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       btn_up, btn_down, btn_pause;
  logic [1:0] status;
  logic       paused;

  speed_ctrl #(.DEBOUNCE_CYCLES(DB)) dut (
    .clk(clk), .rst_n(rst_n), .btn_up(btn_up), .btn_down(btn_down),
    .btn_pause(btn_pause), .status(status), .paused(paused)
  );

  always #5 clk = ~clk;

  int         n_tests = 0;
  int         n_fail  = 0;
  int         cyc     = 0;
  int         last_change_cyc = 0;
  bit         mon_en  = 1'b0;
  logic [2:0] last_obs = 3'b000;
  logic [2:0] exp_q[$];

  int         m_state = 0;
  int         m_saved = 0;

  always @(posedge clk) cyc++;

  task automatic check(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every visible change of {status, paused} must match the next expected entry.
  always @(negedge clk) begin
    if (mon_en && {status, paused} !== last_obs) begin
      last_obs        = {status, paused};
      last_change_cyc = cyc;
      n_tests++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_change: got status=%0d paused=%0d with nothing expected (cycle %0d)",
                 status, paused, cyc);
      end else begin
        logic [2:0] e;
        e = exp_q.pop_front();
        if ({status, paused} !== e) begin
          n_fail++;
          $display("FAIL output_change: got status=%0d paused=%0d expected status=%0d paused=%0d (cycle %0d)",
                   status, paused, e[2:1], e[0], cyc);
        end
      end
    end
  end

  function automatic void push_state();
    logic [1:0] s;
    s = 2'(m_state);
    exp_q.push_back({s, (m_state == 3)});
  endfunction

  // Reference: m = {pause, down, up} presses arriving together.
  function automatic void model_press(input logic [2:0] m);
    int old;
    old = m_state;
    if (m[2]) begin
      if (m_state == 3) m_state = m_saved;
      else begin m_saved = m_state; m_state = 3; end
    end else if (m_state != 3 && m[0] != m[1]) begin
      if (m[0]) m_state = (m_state < 2) ? m_state + 1 : 2;
      else      m_state = (m_state > 0) ? m_state - 1 : 0;
    end
    if (m_state != old) push_state();
  endfunction

  task automatic set_btns(input logic [2:0] m);
    {btn_pause, btn_down, btn_up} = m;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic press_btn(input logic [2:0] m, input int hold);
    set_btns(m);
    model_press(m);
    idle(hold);
    set_btns(3'b000);
    idle(10);
  endtask

  initial begin
    int start;
    rst_n = 1'b0;
    set_btns(3'b000);

    // Reset with buttons toggling
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      set_btns(3'($urandom_range(0, 7)));
    end
    check("reset_status", status, 0);
    check("reset_paused", paused, 0);
    set_btns(3'b000);
    idle(2);
    mon_en = 1'b1;
    rst_n  = 1'b1;
    idle(20);
    check("idle_after_reset", status, 0);

    // Clean up press with edge-accurate latency
    start = cyc;
    press_btn(3'b001, 20);
    check("up_latency_cycles", last_change_cyc - start, DB + 4);
    check("status_mid", status, 1);
    press_btn(3'b001, 20);
    check("status_high", status, 2);
    press_btn(3'b001, 20);
    check("status_saturate_high", status, 2);

    // Bouncing down button
    for (int r = 0; r < 5; r++) begin
      btn_down = 1'b1; idle(3);
      btn_down = 1'b0; idle(1);
    end
    start = cyc;
    press_btn(3'b010, 12);
    check("bounce_latency_cycles", last_change_cyc - start, DB + 4);
    check("bounce_single_dec", status, 1);

    // Pause round trip from MID
    press_btn(3'b100, 8);
    check("paused_status", status, 3);
    check("paused_flag", paused, 1);
    press_btn(3'b001, 8);
    check("up_ignored_in_pause", status, 3);
    press_btn(3'b100, 8);
    check("resume_mid", status, 1);
    check("resume_flag", paused, 0);

    // Simultaneous raw edges
    press_btn(3'b010, 8);
    press_btn(3'b101, 8);
    check("up_pause_together", status, 3);
    press_btn(3'b100, 8);
    check("saved_low_resume", status, 0);
    press_btn(3'b001, 8);
    press_btn(3'b011, 8);
    check("up_down_cancel", status, 1);

    // Reset while paused with a debounce count in flight
    press_btn(3'b100, 8);
    btn_up = 1'b1;
    idle(4);
    exp_q.push_back(3'b000);
    m_state = 0;
    m_saved = 0;
    rst_n = 1'b0;
    idle(2);
    check("midrun_reset_status", status, 0);
    check("midrun_reset_paused", paused, 0);
    btn_up = 1'b0;
    idle(2);
    rst_n = 1'b1;
    idle(10);
    press_btn(3'b100, 8);
    check("pause_after_reset", status, 3);
    press_btn(3'b100, 8);
    check("resume_lost_memory", status, 0);

    // Random presses and sub-threshold glitches
    for (int i = 0; i < 60; i++) begin
      if ($urandom_range(0, 3) == 0) begin
        set_btns(3'(1 << $urandom_range(0, 2)));
        idle($urandom_range(1, DB - 1));
        set_btns(3'b000);
        idle(8);
      end else begin
        press_btn(3'($urandom_range(1, 7)), $urandom_range(6, 14));
      end
    end
    idle(20);
    check("random_final_status", status, m_state);
    check("queue_drained", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
